// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
// Op encodings are shared with the instruction decoder.
package mdu_pkg;

   localparam logic [2:0] MDU_MUL  = 3'b000;
   localparam logic [2:0] MDU_MULH = 3'b001;
   localparam logic [2:0] MDU_DIV  = 3'b010;
   localparam logic [2:0] MDU_DIVU = 3'b011;
   localparam logic [2:0] MDU_REM  = 3'b100;
   localparam logic [2:0] MDU_REMU = 3'b101;

   localparam int MDU_LATENCY = 33;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } mdu_state_e;

   // MUL, MULH, DIV and REM work on operand magnitudes
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_MUL) || (op == MDU_MULH) ||
             (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative multiply/divide, fixed 33-cycle latency.
// Multiply and divide share magnitude regs, counter and one adder.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      mdu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   mdu_state_e      r_state;
   mdu_state_e      w_next;
   logic [2:0]      r_op;
   logic            r_sa;
   logic            r_sb;
   logic            r_bz;
   logic            r_ovf;
   logic [XLEN-1:0] r_mb;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [CW-1:0]   r_cnt;
   logic            r_done;
   logic [XLEN-1:0] r_result;

   logic            w_sa_in;
   logic            w_sb_in;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic            w_is_mul;
   logic [XLEN:0]   w_shift;
   logic [XLEN:0]   w_add_a;
   logic [XLEN:0]   w_add_b;
   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_acc;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0] w_quo_s;
   logic [XLEN-1:0] w_rem_s;
   logic [XLEN-1:0] w_fix_res;
   logic            w_last;

   assign busy   = (r_state != ST_IDLE);
   assign done   = r_done;
   assign result = r_result;

   assign w_sa_in = is_signed_op(mdu_op) & op_a[XLEN-1];
   assign w_sb_in = is_signed_op(mdu_op) & op_b[XLEN-1];
   assign w_mag_a = w_sa_in ? (~op_a + 1'b1) : op_a;
   assign w_mag_b = w_sb_in ? (~op_b + 1'b1) : op_b;

   // shared adder: add for shift-add multiply, subtract for restoring divide
   assign w_is_mul = (r_op == MDU_MUL) || (r_op == MDU_MULH);
   assign w_shift  = {r_hi, r_lo[XLEN-1]};
   assign w_add_a  = w_is_mul ? {1'b0, r_hi} : w_shift;
   assign w_add_b  = {1'b0, r_mb};
   assign w_sum    = w_is_mul ? (w_add_a + w_add_b) : (w_add_a - w_add_b);
   assign w_acc    = r_lo[0] ? w_sum : {1'b0, r_hi};
   assign w_last   = (r_cnt == CW'(XLEN - 1));

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
   assign w_quo_s  = (r_sa ^ r_sb) ? (~r_lo + 1'b1) : r_lo;
   assign w_rem_s  = r_sa ? (~r_hi + 1'b1) : r_hi;

   // final sign correction and special-case override
   always_comb begin
      w_fix_res = '0;
      unique case (r_op)
         MDU_MUL:  w_fix_res = w_prod_s[XLEN-1:0];
         MDU_MULH: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
         MDU_DIV: begin
            if (r_bz)
               w_fix_res = '1;
            else if (r_ovf)
               w_fix_res = {1'b1, {(XLEN-1){1'b0}}};
            else
               w_fix_res = w_quo_s;
         end
         MDU_DIVU: w_fix_res = r_bz ? '1 : r_lo;
         MDU_REM:  w_fix_res = r_ovf ? '0 : w_rem_s;
         MDU_REMU: w_fix_res = r_hi;
         default:  w_fix_res = '0;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (start) w_next = ST_CALC;
         ST_CALC: if (w_last) w_next = ST_FIX;
         ST_FIX:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // datapath: operand latch, one iteration per CALC cycle, result write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_bz     <= 1'b0;
         r_ovf    <= 1'b0;
         r_mb     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_op  <= mdu_op;
                  r_sa  <= w_sa_in;
                  r_sb  <= w_sb_in;
                  r_bz  <= (op_b == '0);
                  r_ovf <= (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                           (op_b == '1);
                  r_mb  <= w_mag_b;
                  r_hi  <= '0;
                  r_lo  <= w_mag_a;
                  r_cnt <= '0;
               end
            end
            ST_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_is_mul) begin
                  r_hi <= w_acc[XLEN:1];
                  r_lo <= {w_acc[0], r_lo[XLEN-1:1]};
               end else begin
                  r_hi <= w_sum[XLEN] ? w_shift[XLEN-1:0]
                                      : w_sum[XLEN-1:0];
                  r_lo <= {r_lo[XLEN-2:0], ~w_sum[XLEN]};
               end
            end
            ST_FIX: begin
               r_result <= w_fix_res;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized + directed scoreboard bench for mdu_iter.
// Expected results come from plain 64-bit arithmetic.
module tb_mdu_iter;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mdu_op = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [31:0] last_res = '0;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t q[$];

   mdu_iter #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mdu_op(mdu_op),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_model(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa;
      longint sb;
      longint p;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      p = 0;
      up = 0;
      case (op)
         MDU_MUL: begin p = sa * sb; return p[31:0]; end
         MDU_MULH: begin p = sa * sb; return p[63:32]; end
         MDU_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return 32'h8000_0000;
            p = sa / sb;
            return p[31:0];
         end
         MDU_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            p = sa % sb;
            return p[31:0];
         end
         MDU_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            up = ua / ub;
            return up[31:0];
         end
         MDU_REMU: begin
            if (b == 0) return a;
            up = ua % ub;
            return up[31:0];
         end
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops expected results whenever the DUT signals done
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy_done_excl", {31'b0, busy & done}, 32'h0);
         if (done) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done result=%h t=%0t",
                        result, $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("result", result, e.res);
               chk("latency_cycle", 32'(cyc), 32'(e.due));
            end
            last_res = result;
         end else begin
            chk("result_held", result, last_res);
         end
      end
   end

   // drive one start pulse; called at a negedge
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit accept);
      mdu_op = op;
      op_a = a;
      op_b = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (accept) begin
         q.push_back('{res: ref_model(op, a, b), due: cyc + MDU_LATENCY});
         chk("busy_after_start", {31'b0, busy}, 32'h1);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (q.size() != 0 || busy) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d busy=%b want 0/0",
                  q.size(), busy);
         q.delete();
      end
   endtask

   function automatic logic [31:0] pick();
      int s;
      s = $urandom_range(0, 7);
      case (s)
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_done", {31'b0, done}, 32'h0);
      chk("reset_result", result, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 1); drain();
      issue(MDU_MULH, 32'h8000_0000, 32'h8000_0000, 1); drain();
      issue(MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); drain();
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1); drain();
      issue(MDU_REM, 32'hFFFF_FFF9, 32'd2, 1); drain();
      issue(MDU_DIVU, 32'hFFFF_FFFF, 32'd2, 1); drain();
      issue(MDU_REMU, 32'hFFFF_FFFF, 32'd2, 1); drain();
      issue(MDU_DIV, 32'h1234, 32'h0, 1); drain();
      issue(MDU_DIVU, 32'h1234, 32'h0, 1); drain();
      issue(MDU_REM, 32'h1234, 32'h0, 1); drain();
      issue(MDU_REMU, 32'h1234, 32'h0, 1); drain();
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain();
      issue(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain();
      issue(3'b110, 32'h55, 32'h3, 1); drain();
      issue(3'b111, 32'h55, 32'h3, 1); drain();

      // start during busy is ignored
      issue(MDU_DIVU, 32'd1000, 32'd7, 1);
      repeat (9) @(negedge clk);
      issue(MDU_MUL, 32'd5, 32'd5, 0);
      drain();

      // back-to-back start in the done cycle
      issue(MDU_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 1);
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", {31'b0, done}, 32'h1);
      issue(MDU_REMU, 32'hDEAD_BEEF, 32'd1000, 1);
      drain();

      // reset mid-DIV aborts without a done pulse
      issue(MDU_DIV, 32'hFFFF_FF9C, 32'd7, 1);
      repeat (14) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_done", {31'b0, done}, 32'h0);
      chk("abort_result", result, 32'h0);
      q.delete();
      last_res = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(MDU_DIV, 32'hFFFF_FF9C, 32'd7, 1);
      drain();

      for (int i = 0; i < 80; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         issue(op, pick(), pick(), 1);
         drain();
      end

      chk("queue_empty", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
